// File: rtl/hwpe_stream_source_realign.sv
`default_nettype none
// ============================================================================
//  Module   : hwpe_stream_source_realign
//  Brief    : Re-aligns a byte-misaligned packet stream onto word boundaries.
//             The first beat carries valid bytes at the top of the word. Those
//             bytes are shifted down and merged with the next beat. A trailing
//             "last" beat flushes the residual bytes. With realign=0 the block
//             is a zero-latency passthrough.
//  Revision : 1.0 - initial release
// ============================================================================
module hwpe_stream_source_realign #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  test_mode_i,
    // control
    input  logic                  ctrl_enable_i,
    input  logic                  ctrl_realign_i,
    input  logic                  ctrl_first_i,
    input  logic                  ctrl_last_i,
    input  logic                  ctrl_last_packet_i,
    input  logic [STRB_WIDTH-1:0] strb_i,
    // input stream (sink)
    input  logic                  stream_i_valid_i,
    output logic                  stream_i_ready_o,
    input  logic [DATA_WIDTH-1:0] stream_i_data_i,
    input  logic [STRB_WIDTH-1:0] stream_i_strb_i,
    // output stream (source)
    output logic                  stream_o_valid_o,
    input  logic                  stream_o_ready_i,
    output logic [DATA_WIDTH-1:0] stream_o_data_o,
    output logic [STRB_WIDTH-1:0] stream_o_strb_o
);

    localparam int unsigned OFF_WIDTH = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
    localparam logic [STRB_WIDTH-1:0] C_STRB_ONES = {STRB_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic [OFF_WIDTH-1:0]    offset_q, offset_d;

    logic [OFF_WIDTH-1:0]    w_first_offset;
    logic [OFF_WIDTH+2:0]    w_shift_bits;
    logic [2*DATA_WIDTH-1:0] w_cat_shifted;
    logic [DATA_WIDTH-1:0]   w_mid_data;
    logic [DATA_WIDTH-1:0]   w_last_data;
    logic [STRB_WIDTH-1:0]   w_last_strb;

    // Reserved / informational inputs that do not affect behaviour.
    logic w_unused;
    assign w_unused = test_mode_i ^ ctrl_last_packet_i ^ (^stream_i_strb_i);

    // Offset of the first beat = number of empty low-order byte lanes.
    // An all-zero strobe saturates at the largest representable offset.
    always_comb begin
        w_first_offset = OFF_WIDTH'(STRB_WIDTH - 1);
        for (int i = STRB_WIDTH - 1; i >= 0; i--) begin
            if (strb_i[i]) begin
                w_first_offset = OFF_WIDTH'(i);
            end
        end
    end

    // Byte-lane shifter: byte j of {in, R} >> O*8 is R[j+O] for j < N-O,
    // otherwise in[j-(N-O)], which is exactly the middle-beat merge.
    assign w_shift_bits  = {offset_q, 3'b000};
    assign w_cat_shifted = {stream_i_data_i, data_q} >> w_shift_bits;
    assign w_mid_data    = w_cat_shifted[DATA_WIDTH-1:0];
    assign w_last_data   = data_q >> w_shift_bits;
    assign w_last_strb   = C_STRB_ONES >> offset_q;

    // Output/handshake selection and next-state for the R and O registers.
    always_comb begin
        stream_o_valid_o = 1'b0;
        stream_i_ready_o = 1'b0;
        stream_o_data_o  = '0;
        stream_o_strb_o  = '0;
        data_d           = data_q;
        offset_d         = offset_q;

        if (ctrl_enable_i) begin
            if (!ctrl_realign_i) begin
                stream_o_valid_o = stream_i_valid_i;
                stream_i_ready_o = stream_o_ready_i;
                stream_o_data_o  = stream_i_data_i;
                stream_o_strb_o  = stream_i_strb_i;
            end else if (ctrl_first_i) begin
                // First beat only primes the register; nothing is emitted.
                stream_i_ready_o = 1'b1;
                if (stream_i_valid_i) begin
                    data_d   = stream_i_data_i;
                    offset_d = w_first_offset;
                end
            end else if (ctrl_last_i) begin
                // Flush residual bytes without consuming input.
                stream_o_valid_o = 1'b1;
                stream_o_data_o  = w_last_data;
                stream_o_strb_o  = w_last_strb;
            end else begin
                stream_o_valid_o = stream_i_valid_i;
                stream_i_ready_o = stream_o_ready_i;
                stream_o_data_o  = w_mid_data;
                stream_o_strb_o  = C_STRB_ONES;
                if (stream_i_valid_i && stream_o_ready_i) begin
                    data_d = stream_i_data_i;
                end
            end
        end

        if (clear_i) begin
            data_d   = '0;
            offset_d = '0;
        end
    end

    // State registers: asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q   <= '0;
            offset_q <= '0;
        end else begin
            data_q   <= data_d;
            offset_q <= offset_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_source_realign.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hwpe_stream_source_realign
//  Brief    : Self-checking bench for hwpe_stream_source_realign (16-bit, N=2).
//             Directed beats followed by random packets with a byte
//             scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_source_realign;

    localparam int DW = 16;
    localparam int N  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          en, realign, first, last;
    logic [N-1:0]  strb;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic [N-1:0]  in_strb;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_strb;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    exp_q[$];
    logic [N-1:0]  push_mask;
    logic          sb_en = 1'b0;

    always #5 clk = ~clk;

    hwpe_stream_source_realign #(.DATA_WIDTH(DW), .STRB_WIDTH(N)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .test_mode_i        (1'b0),
        .ctrl_enable_i      (en),
        .ctrl_realign_i     (realign),
        .ctrl_first_i       (first),
        .ctrl_last_i        (last),
        .ctrl_last_packet_i (1'b0),
        .strb_i             (strb),
        .stream_i_valid_i   (in_valid),
        .stream_i_ready_o   (in_ready),
        .stream_i_data_i    (in_data),
        .stream_i_strb_i    (in_strb),
        .stream_o_valid_o   (out_valid),
        .stream_o_ready_i   (out_ready),
        .stream_o_data_o    (out_data),
        .stream_o_strb_o    (out_strb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard work at the falling edge, then return 1 ns after
    // the rising edge so the caller can drive the next inputs.
    task automatic cycle(output logic in_hs, output logic out_hs);
        @(negedge clk);
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        if (sb_en) begin
            if (in_hs) begin
                for (int j = 0; j < N; j++)
                    if (push_mask[j]) exp_q.push_back(in_data[8*j +: 8]);
            end
            if (out_hs) begin
                for (int j = 0; j < N; j++) begin
                    if (out_strb[j]) begin
                        if (exp_q.size() == 0) begin
                            check("sb_underflow", 32'(out_data[8*j +: 8]), 32'hFFFF_FFFF);
                        end else begin
                            check("sb_byte", 32'(out_data[8*j +: 8]), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one input beat (first or middle) with random stalls on both sides.
    task automatic in_beat(input logic is_first, input logic [DW-1:0] d, input logic [N-1:0] mask);
        logic ih, oh;
        int   budget;
        first     = is_first;
        last      = 1'b0;
        in_data   = d;
        push_mask = mask;
        budget    = 0;
        ih        = 1'b0;
        while (!ih && budget < 200) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            cycle(ih, oh);
            budget++;
        end
        if (!ih) check("in_beat_timeout", 32'(budget), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic last_beat();
        logic ih, oh;
        int   budget;
        first    = 1'b0;
        last     = 1'b1;
        in_valid = 1'b0;
        budget   = 0;
        oh       = 1'b0;
        while (!oh && budget < 200) begin
            out_ready = ($urandom_range(0, 4) != 0);
            cycle(ih, oh);
            budget++;
        end
        if (!oh) check("last_beat_timeout", 32'(budget), 32'd0);
        last = 1'b0;
    endtask

    initial begin
        logic          ih, oh;
        logic [DW-1:0] r_saved;
        int            off, beats;

        rst_n = 1'b0; clear = 1'b0; en = 1'b0; realign = 1'b0; first = 1'b0; last = 1'b0;
        strb = '0; in_valid = 1'b0; in_data = '0; in_strb = '0; out_ready = 1'b0;
        push_mask = '0;

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_R",         32'(dut.data_q),   32'd0);
        check("rst_O",         32'(dut.offset_q), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Passthrough
        en = 1'b1; realign = 1'b0; in_valid = 1'b1; in_data = 16'hABCD; in_strb = 2'b11; out_ready = 1'b1;
        #1;
        check("pt_data",  32'(out_data),  32'h0000ABCD);
        check("pt_strb",  32'(out_strb),  32'h3);
        check("pt_valid", 32'(out_valid), 32'd1);
        check("pt_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b0;
        #1;
        check("pt_ready_bp", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("pt_R_hold", 32'(dut.data_q), 32'd0);

        // First beat, out.ready low must not matter
        realign = 1'b1; first = 1'b1; strb = 2'b10; in_data = 16'h12EE; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("first_in_ready",  32'(in_ready),  32'd1);
        check("first_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("first_O", 32'(dut.offset_q), 32'd1);
        check("first_R", 32'(dut.data_q),   32'h12EE);

        // Middle beat under backpressure
        first = 1'b0; in_data = 16'h5634; out_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_data",     32'(out_data), 32'h3412);
        @(posedge clk); #1;
        check("bp_R_hold", 32'(dut.data_q), 32'h12EE);
        out_ready = 1'b1;
        #1;
        check("mid_data",     32'(out_data),  32'h3412);
        check("mid_strb",     32'(out_strb),  32'h3);
        check("mid_valid",    32'(out_valid), 32'd1);
        check("mid_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        check("mid_R", 32'(dut.data_q), 32'h5634);

        // Last beat
        last = 1'b1; in_valid = 1'b1;
        #1;
        check("last_data",     32'(out_data),  32'h0056);
        check("last_strb",     32'(out_strb),  32'h1);
        check("last_valid",    32'(out_valid), 32'd1);
        check("last_in_ready", 32'(in_ready),  32'd0);
        @(posedge clk); #1;
        check("last_R_hold", 32'(dut.data_q), 32'h5634);

        // first and last together: first wins
        first = 1'b1; last = 1'b1; strb = 2'b11; in_data = 16'h7788;
        #1;
        check("fl_in_ready",  32'(in_ready),  32'd1);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("fl_R", 32'(dut.data_q),   32'h7788);
        check("fl_O", 32'(dut.offset_q), 32'd0);

        // Disabled: registers hold
        en = 1'b0; strb = 2'b10; in_data = 16'h9999;
        #1;
        check("dis_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("dis_R_hold", 32'(dut.data_q), 32'h7788);

        // Clear beats a simultaneous load
        en = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_R", 32'(dut.data_q),   32'd0);
        check("clr_O", 32'(dut.offset_q), 32'd0);
        first = 1'b0; last = 1'b0; in_valid = 1'b0;

        // Random packets against the byte scoreboard
        sb_en = 1'b1; realign = 1'b1;
        for (int p = 0; p < 40; p++) begin
            off   = $urandom_range(0, N - 1);
            beats = $urandom_range(2, 16);
            strb  = N'({N{1'b1}} << off);
            in_beat(1'b1, DW'($urandom), strb);
            for (int b = 0; b < beats - 2; b++)
                in_beat(1'b0, DW'($urandom), {N{1'b1}});
            last_beat();
        end
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        // Reset mid-packet
        sb_en = 1'b0;
        strb = 2'b10;
        in_beat(1'b1, 16'hBEEF, strb);
        in_beat(1'b0, 16'hCAFE, {N{1'b1}});
        r_saved = dut.data_q;
        check("pre_rst_R", 32'(r_saved), 32'h0000CAFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_R", 32'(dut.data_q),   32'd0);
        check("mid_rst_O", 32'(dut.offset_q), 32'd0);
        cycle(ih, oh);
        rst_n = 1'b1;
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwpe_stream_source_realign.md
HWPE_STREAM_SOURCE_REALIGN -- requirements
Module: hwpe_stream_source_realign

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream data width in bits, a multiple of 8.
REQ-002 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: byte count N.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous clear of internal state.
REQ-006 SHALL have port test_mode_i, input, 1 bit: reserved, functionally ignored.
REQ-007 SHALL have port ctrl_i, input, ctrl_realign_t: fields enable, realign, first, last, last_packet (last_packet is ignored).
REQ-008 SHALL have port strb_i, input, N bits: byte strobe of the current input beat.
REQ-009 SHALL have port stream_i, hwpe_stream_intf_stream sink: valid, ready, data[DATA_WIDTH], strb[N].
REQ-010 SHALL have port stream_o, hwpe_stream_intf_stream source: valid, ready, data[DATA_WIDTH], strb[N].

Function
REQ-011 SHALL, when ctrl_i.enable=0, drive stream_o.valid=0 and stream_i.ready=0, and hold all registers.
REQ-012 SHALL, when enable=1 and realign=0, pass through combinationally with zero latency:
- data, strb and valid from stream_i to stream_o
- stream_i.ready = stream_o.ready
REQ-013 SHALL keep a data register R (DATA_WIDTH bits) and an offset register O (0..N-1 bytes).
REQ-014 SHALL, on a first beat (enable, realign and first all 1), meet all of:
- stream_i.ready=1 regardless of stream_o.ready
- stream_o.valid=0
- on the stream_i.valid handshake, R is loaded with stream_i.data
- O is loaded with the count of low-order zero bits of strb_i; valid bytes sit at the top of the word.
REQ-015 SHALL, on a middle beat (enable=1, realign=1, first=0, last=0), meet all of:
- stream_o.valid = stream_i.valid
- stream_i.ready = stream_o.ready
- stream_o.strb = all ones
- stream_o.data byte j = R byte (j+O) for j < N-O
- stream_o.data byte j = stream_i.data byte (j-(N-O)) for j >= N-O
- on the handshake, R is loaded with stream_i.data.
REQ-016 SHALL, on a last beat (enable=1, realign=1, last=1), meet all of:
- emit the residual word without consuming input: stream_i.ready=0 and stream_o.valid=1
- stream_o.data byte j = R byte (j+O) for j < N-O, all other bytes 0
- stream_o.strb = low N-O bits set.
REQ-017 SHALL treat O=0 with realign=1 as a plain registered shift: every middle output equals the previous input word.
REQ-018 SHALL, when first and last are both 1, give first priority.
REQ-019 SHALL, under backpressure (stream_o.ready=0), keep R and O unchanged and keep the output stable while valid.
REQ-020 SHALL update no register unless enable=1 and a stream_i handshake occurs.
REQ-021 SHALL not compare stream_i.strb with strb_i; strb_i alone defines O.

Reset
REQ-022 SHALL, while rst_ni=0 (asynchronous), set R=0 and O=0; outputs then follow REQ-011/012 combinationally.
REQ-023 SHALL, on clear_i=1 at a rising edge, set R=0 and O=0, with clear_i taking priority over any load.
REQ-024 SHALL, on a reset or clear mid-packet, discard the packet; the next packet starts with a first beat.

Verification (DATA_WIDTH=16, N=2)
REQ-025 Passthrough: realign=0, in 0xABCD, strb 2'b11, out.ready=1 -> out 0xABCD, strb 2'b11, valid in the same cycle.
REQ-026 First beat: realign=1, first=1, strb_i=2'b10, in 0x12xx -> in.ready=1, out.valid=0, O=1, R=0x12xx.
REQ-027 Middle beat: next in 0x5634 -> out 0x3412, strb 2'b11, R=0x5634.
REQ-028 Last beat: last=1 -> out 0x0056, strb 2'b01, valid=1, in.ready=0.
REQ-029 Backpressure: out.ready=0 on a middle beat -> in.ready=0 and R held; releasing it yields the identical output word.
REQ-030 Random packets (2..16 beats, random offset, 20% stall on both sides) -> concatenated valid input bytes equal concatenated output bytes; then assert rst_ni mid-packet -> R=0, O=0.
